// File: rtl/moving_rank_pkg.sv
// Shared constants and elaboration helpers for the moving rank filter.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default sample width and window length
//   latency()                     : accepting edge to OutValid edge, in cycles
//   depth_is_legal()              : window length must be odd, 3..15
package moving_rank_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH = 5;

  // Window capture + launch register + DEPTH sort stages + output register
  function automatic int unsigned latency(input int unsigned depth);
    return depth + 2;
  endfunction

  function automatic bit depth_is_legal(input int unsigned depth);
    return (depth >= 3) && (depth <= 15) && ((depth % 2) == 1);
  endfunction

endpackage

// File: rtl/moving_rank_filter_cmp_exchange.sv
// One registered signed compare-exchange cell of the sort network.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   i_a, i_b   : pair entering the cell (i_a is the lower lane)
//   o_lo, o_hi : registered smaller / larger value; equal values keep order
module cmp_exchange #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             w_swap;

  // Strict compare so equal values never swap
  assign w_swap = $signed(i_a) > $signed(i_b);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      r_lo <= w_swap ? i_b : i_a;
      r_hi <= w_swap ? i_a : i_b;
    end
  end

  assign o_lo = r_lo;
  assign o_hi = r_hi;

endmodule

// File: rtl/moving_rank_filter.sv
// Moving rank-order filter: selects the Rank-th smallest of the last DEPTH
// accepted samples using a pipelined odd-even transposition sort.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   Clear      : synchronous window flush (drops in-flight results)
//   InValid    : qualifies Input
//   Input      : signed sample
//   Rank       : 0 = min, DEPTH-1 = max; larger values saturate
//   OutValid   : one-cycle pulse with each new result
//   Output     : selected-rank value, held between pulses
//   Primed     : window holds DEPTH samples since last Reset/Clear
module moving_rank_filter
  import moving_rank_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned RW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             InValid,
  input  logic [WIDTH-1:0] Input,
  input  logic [RW-1:0]    Rank,
  output logic             OutValid,
  output logic [WIDTH-1:0] Output,
  output logic             Primed
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("moving_rank_filter: DEPTH must be odd and within 3..15");
  end

  logic [WIDTH-1:0] r_window [DEPTH];
  logic [CW-1:0]    r_fill;
  logic             r_primed;
  logic             r_acc_valid;
  logic [RW-1:0]    r_acc_rank;
  logic [CW-1:0]    w_fill_base;
  logic [CW-1:0]    w_fill_next;

  logic [WIDTH-1:0] r_launch [DEPTH];
  logic [WIDTH-1:0] w_stg [DEPTH+1][DEPTH];
  logic [DEPTH:0]   r_tag;
  logic [RW-1:0]    r_rank [DEPTH+1];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic [RW-1:0]    w_rank_sat;
  logic [WIDTH-1:0] w_sel;

  // Fill count as seen after an optional flush, then saturating increment
  always_comb begin
    w_fill_base = Clear ? '0 : r_fill;
    w_fill_next = (w_fill_base == CW'(DEPTH)) ? w_fill_base : w_fill_base + CW'(1);
  end

  // Sample window, fill count and the tag/rank of the accepted sample
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int j = 0; j < DEPTH; j++) r_window[j] <= '0;
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_acc_valid <= 1'b0;
      r_acc_rank  <= '0;
    end else if (InValid) begin
      r_window[0] <= Input;
      for (int j = 1; j < DEPTH; j++) r_window[j] <= Clear ? '0 : r_window[j-1];
      r_fill      <= w_fill_next;
      r_primed    <= (w_fill_next == CW'(DEPTH));
      r_acc_valid <= (w_fill_next == CW'(DEPTH));
      r_acc_rank  <= Rank;
    end else begin
      if (Clear) begin
        for (int j = 0; j < DEPTH; j++) r_window[j] <= '0;
        r_fill   <= '0;
        r_primed <= 1'b0;
      end
      r_acc_valid <= 1'b0;
    end
  end

  // Launch snapshot plus tag/rank side pipeline; Clear kills every tag in flight
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int j = 0; j < DEPTH; j++) r_launch[j] <= '0;
      for (int s = 0; s <= DEPTH; s++) r_rank[s] <= '0;
      r_tag <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) r_launch[j] <= r_window[j];
      r_tag[0]  <= r_acc_valid & ~Clear;
      r_rank[0] <= r_acc_rank;
      for (int s = 1; s <= DEPTH; s++) begin
        r_tag[s]  <= r_tag[s-1] & ~Clear;
        r_rank[s] <= r_rank[s-1];
      end
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_launch
    assign w_stg[0][j] = r_launch[j];
  end

  // Odd-even transposition network: even stages pair (0,1),(2,3)..., odd stages (1,2),(3,4)...
  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    localparam int unsigned FIRST = 32'(s % 2);
    localparam int unsigned PASS  = (FIRST == 0) ? DEPTH - 1 : 0;

    for (genvar p = FIRST; p + 1 < DEPTH; p += 2) begin : g_pair
      cmp_exchange #(.WIDTH(WIDTH)) u_cmp (
        .Clk   (Clk),
        .Reset (Reset),
        .i_a   (w_stg[s][p]),
        .i_b   (w_stg[s][p+1]),
        .o_lo  (w_stg[s+1][p]),
        .o_hi  (w_stg[s+1][p+1])
      );
    end

    // Unpaired lane is delayed to stay aligned with its neighbours
    logic [WIDTH-1:0] r_pass;
    always_ff @(posedge Clk) begin
      if (Reset) r_pass <= '0;
      else       r_pass <= w_stg[s][PASS];
    end
    assign w_stg[s+1][PASS] = r_pass;
  end

  // Rank select with saturation to the top lane
  always_comb begin
    w_rank_sat = r_rank[DEPTH];
    if (32'(r_rank[DEPTH]) >= DEPTH) w_rank_sat = RW'(DEPTH - 1);
    w_sel = w_stg[DEPTH][0];
    for (int j = 0; j < DEPTH; j++) begin
      if (w_rank_sat == RW'(j)) w_sel = w_stg[DEPTH][j];
    end
  end

  // Output register: Clear suppresses the pulse but leaves Output untouched
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (Clear) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_tag[DEPTH];
      if (r_tag[DEPTH]) r_out <= w_sel;
    end
  end

  assign OutValid = r_out_valid;
  assign Output   = r_out;
  assign Primed   = r_primed;

endmodule
